bcd_down_counter: RTL and testbench

Multi-digit BCD down-counter with parallel load, a borrow chain and optional auto-reload. It is the decrementing counterpart of the team's BCD up-counter and is used for countdown timers and for unwinding BCD tallies digit by digit. All outputs are registered. One clock domain.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_down_counter_if.sv | 23 ++
 rtl/bcd_down_digit.sv | 39 +++
 rtl/bcd_down_counter.sv | 124 ++++++++++++
 tb/tb_bcd_down_counter.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, the underflow/load action encoding and the nibble clamp helper.
package bcd_pkg;

    localparam int unsigned BCD_W    = 4;
    localparam logic [3:0]  BCD_MAX  = 4'd9;
    localparam logic [3:0]  BCD_ZERO = 4'd0;

    // What the counter does at the coming edge, in priority order.
    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_DEC,
        ACT_RELOAD,
        ACT_WRAP
    } bcd_act_e;

    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

    function automatic logic bcd_invalid(input logic [BCD_W-1:0] nibble);
        return nibble > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control inputs and registered status outputs of the BCD down-counter.
interface bcd_down_counter_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  Load;
    logic [4*DIGITS-1:0]   Load_val;
    logic                  Bin;
    logic                  Auto_reload;
    logic [4*DIGITS-1:0]   q;
    logic                  Bout;
    logic                  Zero;
    logic                  Load_err;

    modport master (
        output Load, Load_val, Bin, Auto_reload,
        input  q, Bout, Zero, Load_err
    );

    modport slave (
        input  Load, Load_val, Bin, Auto_reload,
        output q, Bout, Zero, Load_err
    );
endinterface

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: load, decrement with 0 -> 9 wrap, combinational borrow-out.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [BCD_W-1:0] load_val_i,
    input  logic             bin_i,
    output logic [BCD_W-1:0] digit_o,
    output logic [BCD_W-1:0] digit_d_o,
    output logic             bout_o
);

    logic [BCD_W-1:0] digit_q;
    logic [BCD_W-1:0] digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_val_i;
        end else if (bin_i) begin
            digit_d = (digit_q == BCD_ZERO) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            digit_q <= BCD_ZERO;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o   = digit_q;
    assign digit_d_o = digit_d;
    assign bout_o    = bin_i && (digit_q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter: parallel load with clamp, borrow chain, wrap or auto-reload on underflow.
module bcd_down_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                Clk,
    input  logic                Rst_n,
    bcd_down_counter_if.slave   bus
);

    localparam int unsigned W = BCD_W * DIGITS;

    logic [W-1:0]    q_cur;
    logic [W-1:0]    q_next;
    logic [DIGITS:0] borrow;

    logic [W-1:0]    load_clamped;
    logic            load_bad;
    logic            dec_en;
    logic            underflow;
    bcd_act_e        act;

    logic            digit_load;
    logic [W-1:0]    digit_load_val;

    logic [W-1:0]    reload_q;
    logic [W-1:0]    reload_d;
    logic            bout_q;
    logic            bout_d;
    logic            zero_q;
    logic            zero_d;
    logic            load_err_q;
    logic            load_err_d;

    always_comb begin
        load_clamped = '0;
        load_bad     = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            load_clamped[i*BCD_W +: BCD_W] = bcd_clamp(bus.Load_val[i*BCD_W +: BCD_W]);
            load_bad = load_bad | bcd_invalid(bus.Load_val[i*BCD_W +: BCD_W]);
        end
    end

    // Load outranks Bin, so the borrow chain only runs when no load is pending.
    assign dec_en    = bus.Bin && !bus.Load;
    assign borrow[0] = dec_en;
    assign underflow = borrow[DIGITS];

    always_comb begin
        act = ACT_HOLD;
        if (bus.Load) begin
            act = ACT_LOAD;
        end else if (dec_en) begin
            if (!underflow) begin
                act = ACT_DEC;
            end else if (bus.Auto_reload) begin
                act = ACT_RELOAD;
            end else begin
                act = ACT_WRAP;
            end
        end
    end

    // Wrap needs no load: every digit sees a borrow at 0 and turns to 9 on its own.
    always_comb begin
        digit_load     = 1'b0;
        digit_load_val = load_clamped;
        unique case (act)
            ACT_LOAD: begin
                digit_load     = 1'b1;
                digit_load_val = load_clamped;
            end
            ACT_RELOAD: begin
                digit_load     = 1'b1;
                digit_load_val = reload_q;
            end
            default: begin
                digit_load     = 1'b0;
                digit_load_val = load_clamped;
            end
        endcase
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .clk_i      (Clk),
            .rst_ni     (Rst_n),
            .load_i     (digit_load),
            .load_val_i (digit_load_val[g*BCD_W +: BCD_W]),
            .bin_i      (borrow[g]),
            .digit_o    (q_cur[g*BCD_W +: BCD_W]),
            .digit_d_o  (q_next[g*BCD_W +: BCD_W]),
            .bout_o     (borrow[g+1])
        );
    end

    always_comb begin
        reload_d   = (act == ACT_LOAD) ? load_clamped : reload_q;
        bout_d     = (act == ACT_RELOAD) || (act == ACT_WRAP);
        load_err_d = (act == ACT_LOAD) && load_bad;
        zero_d     = (q_next == '0);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            reload_q   <= '0;
            bout_q     <= 1'b0;
            zero_q     <= 1'b1;
            load_err_q <= 1'b0;
        end else begin
            reload_q   <= reload_d;
            bout_q     <= bout_d;
            zero_q     <= zero_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.q        = q_cur;
    assign bus.Bout     = bout_q;
    assign bus.Zero     = zero_q;
    assign bus.Load_err = load_err_q;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter: integer-valued reference model, per-cycle compare, directed and random stimulus.
module tb_bcd_down_counter;

    localparam int D    = 4;
    localparam int W    = 4 * D;
    localparam int MAXV = 9999;

    logic Clk;
    logic Rst_n;

    bcd_down_counter_if #(.DIGITS(D)) bif ();

    bcd_down_counter #(.DIGITS(D)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bif)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model keeps the count as a plain integer; BCD only appears at the boundary.
    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = D - 1; i >= 0; i--) begin
            logic [3:0] n;
            n = v[i*4 +: 4];
            if (n > 4'd9) n = 4'd9;
            r = r * 10 + int'(n);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int x);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = x;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] v);
        bit b;
        b = 1'b0;
        for (int i = 0; i < D; i++) begin
            if (v[i*4 +: 4] > 4'd9) b = 1'b1;
        end
        return b;
    endfunction

    int m_cnt;
    int m_reload;
    bit m_bout;
    bit m_err;

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            m_cnt    <= 0;
            m_reload <= 0;
            m_bout   <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_bout <= 1'b0;
            m_err  <= 1'b0;
            if (bif.Load) begin
                m_cnt    <= bcd2int(bif.Load_val);
                m_reload <= bcd2int(bif.Load_val);
                m_err    <= has_bad(bif.Load_val);
            end else if (bif.Bin) begin
                if (m_cnt == 0) begin
                    m_bout <= 1'b1;
                    m_cnt  <= bif.Auto_reload ? m_reload : MAXV;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("q",        {16'h0, bif.q},   {16'h0, int2bcd(m_cnt)});
            chk("Bout",     {31'h0, bif.Bout},     {31'h0, m_bout});
            chk("Zero",     {31'h0, bif.Zero},     {31'h0, (m_cnt == 0)});
            chk("Load_err", {31'h0, bif.Load_err}, {31'h0, m_err});
        end
    end

    task automatic cyc(input logic ld, input logic [W-1:0] v, input logic b, input logic ar);
        bif.Load        = ld;
        bif.Load_val    = v;
        bif.Bin         = b;
        bif.Auto_reload = ar;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < D; i++) begin
            if ($urandom_range(0, 7) == 0) v[i*4 +: 4] = 4'($urandom_range(10, 15));
            else v[i*4 +: 4] = 4'($urandom_range(0, 9));
        end
        // Small values make underflow frequent.
        if ($urandom_range(0, 1) == 0) v[W-1:8] = '0;
        return v;
    endfunction

    int exp_q[8] = '{2, 1, 0, 3, 2, 1, 0, 3};
    bit exp_b[8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    int bouts;

    initial begin
        Rst_n           = 1'b0;
        bif.Load        = 1'b0;
        bif.Load_val    = '0;
        bif.Bin         = 1'b0;
        bif.Auto_reload = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_q",    {16'h0, bif.q},        32'h0);
        chk("rst_zero", {31'h0, bif.Zero},     32'h1);
        chk("rst_bout", {31'h0, bif.Bout},     32'h0);
        chk("rst_err",  {31'h0, bif.Load_err}, 32'h0);
        Rst_n  = 1'b1;
        chk_en = 1'b1;

        // Reset mid-count at 0437 takes effect without a clock edge.
        cyc(1'b1, 16'h0437, 1'b0, 1'b0);
        chk("ld_0437", {16'h0, bif.q}, 32'h0437);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("async_q",    {16'h0, bif.q},    32'h0);
        chk("async_zero", {31'h0, bif.Zero}, 32'h1);
        chk("async_bout", {31'h0, bif.Bout}, 32'h0);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;

        // Load and borrow cascade down to zero.
        cyc(1'b1, 16'h1000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("cascade_0999", {16'h0, bif.q}, 32'h0999);
        bouts = 0;
        repeat (999) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b0);
            if (bif.Bout) bouts++;
        end
        chk("cascade_end_q",    {16'h0, bif.q},    32'h0);
        chk("cascade_end_zero", {31'h0, bif.Zero}, 32'h1);
        chk("cascade_no_bout",  32'(bouts),        32'h0);

        // Wrap to all nines.
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wrap_q",    {16'h0, bif.q},    32'h9999);
        chk("wrap_bout", {31'h0, bif.Bout}, 32'h1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("wrap2_q",    {16'h0, bif.q},    32'h9998);
        chk("wrap2_bout", {31'h0, bif.Bout}, 32'h0);

        // Auto-reload from 0003.
        cyc(1'b1, 16'h0003, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1);
            chk("ar_q",    {16'h0, bif.q},    32'(exp_q[i]));
            chk("ar_bout", {31'h0, bif.Bout}, {31'h0, exp_b[i]});
        end

        // Load beats Bin; invalid nibble clamps to 9.
        cyc(1'b1, 16'h0A25, 1'b1, 1'b0);
        chk("clamp_q",    {16'h0, bif.q},        32'h0925);
        chk("clamp_err",  {31'h0, bif.Load_err}, 32'h1);
        chk("clamp_bout", {31'h0, bif.Bout},     32'h0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("clamp_dec_q",   {16'h0, bif.q},        32'h0924);
        chk("clamp_dec_err", {31'h0, bif.Load_err}, 32'h0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("clamp_dec2_q", {16'h0, bif.q}, 32'h0923);

        // Zero reload value: stays at zero, Bout every cycle.
        cyc(1'b1, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 16'h0, 1'b1, 1'b1);
            chk("zr_q",    {16'h0, bif.q},    32'h0);
            chk("zr_bout", {31'h0, bif.Bout}, 32'h1);
            chk("zr_zero", {31'h0, bif.Zero}, 32'h1);
        end

        // Random traffic, with one asynchronous reset part-way.
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) begin
                #2;
                Rst_n = 1'b0;
                #1;
                chk("rand_async_q", {16'h0, bif.q}, 32'h0);
                @(posedge Clk);
                #1;
                Rst_n = 1'b1;
            end
            cyc(($urandom_range(0, 15) == 0), rand_val(),
                ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge Clk);
        chk_en = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
